// File: rtl/weight_match_ctrl.sv
// Weight-matching controller: buffers a text string, then compares per-lane weight chunks against it.
// Optional saturating match counter enabled by defining MATCH_COUNT_EN.
module weight_match_ctrl #(
    parameter int DWIDTH   = 8,
    parameter int num      = 4,
    parameter int TEXT_LEN = 64
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [DWIDTH-1:0]               text_in,
    input  logic                            text_valid,
    input  logic                            text_last,
    input  logic [num*num*DWIDTH-1:0]       weight_cut,
    input  logic                            weight_enable,
    input  logic                            string_finish,
    output logic                            string_ready,
    output logic [num:0]                    signal_from_controller,
    output logic                            match_valid,
    output logic [num-1:0]                  match_lanes,
    output logic [15:0]                     match_count,
    output logic                            busy,
    output logic [2:0]                      dbg_state,
    output logic [$clog2(TEXT_LEN+1)-1:0]   dbg_text_len
);

    localparam int PW     = $clog2(TEXT_LEN + 1);
    localparam int AW     = (TEXT_LEN > 1) ? $clog2(TEXT_LEN) : 1;
    localparam int CHUNKS = TEXT_LEN / num;
    localparam int OW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] RUN  = 3'd2;
    localparam logic [2:0] CMP  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     text_len_q, text_len_d;
    logic [OW-1:0]     off_q [num];
    logic [OW-1:0]     off_d [num];
    logic              seen_we_q, seen_we_d;
    logic              string_ready_q, string_ready_d;
    logic [num:0]      sfc_q, sfc_d;
    logic              match_valid_q, match_valid_d;
    logic [num-1:0]    match_lanes_q, match_lanes_d;
    logic              text_we;

    logic [DWIDTH-1:0] text_mem [TEXT_LEN];

    logic [num-1:0]    lane_ok, lane_fin, cont, lane_hit;
    logic              pad_r;
    int                pos_r;
    logic [DWIDTH-1:0] w_r;

    // Once a lane's chunk hits a 0x00 byte, that byte and everything after it is padding.
    always_comb begin
        lane_ok  = '1;
        lane_fin = '0;
        cont     = '0;
        lane_hit = '0;
        pad_r    = 1'b0;
        pos_r    = 0;
        w_r      = '0;
        for (int i = 0; i < num; i++) begin
            pad_r = 1'b0;
            for (int j = 0; j < num; j++) begin
                w_r   = weight_cut[(i*num+j)*DWIDTH +: DWIDTH];
                pos_r = int'(off_q[i]) * num + j;
                if (w_r == '0) pad_r = 1'b1;
                if (!pad_r && ((pos_r >= int'(text_len_q)) || (text_mem[pos_r[AW-1:0]] != w_r)))
                    lane_ok[i] = 1'b0;
            end
            lane_fin[i] = pad_r;
            cont[i]     = lane_ok[i] & ~pad_r & ((int'(off_q[i]) + 1) < CHUNKS);
            lane_hit[i] = lane_ok[i] & pad_r;
        end
    end

    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        text_len_d     = text_len_q;
        off_d          = off_q;
        seen_we_d      = seen_we_q;
        string_ready_d = 1'b0;
        sfc_d          = '0;
        match_valid_d  = 1'b0;
        match_lanes_d  = '0;
        text_we        = 1'b0;
        case (state_q)
            IDLE, LOAD: begin
                if (text_valid) begin
                    text_we = (wr_ptr_q < PW'(TEXT_LEN));
                    if (text_we) wr_ptr_d = wr_ptr_q + PW'(1);
                    if (text_last) begin
                        text_len_d     = text_we ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
                        wr_ptr_d       = '0;
                        string_ready_d = 1'b1;
                        seen_we_d      = 1'b0;
                        for (int i = 0; i < num; i++) off_d[i] = '0;
                        state_d        = RUN;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            RUN: begin
                // A chunk arriving together with the finish strobe is discarded.
                if (string_finish && seen_we_q) begin
                    state_d = DONE;
                end else if (weight_enable) begin
                    seen_we_d     = 1'b1;
                    sfc_d         = {1'b1, cont};
                    match_valid_d = |lane_hit;
                    match_lanes_d = lane_hit;
                    for (int i = 0; i < num; i++)
                        off_d[i] = cont[i] ? (off_q[i] + OW'(1)) : '0;
                    state_d       = CMP;
                end
            end
            CMP:     state_d = RUN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!enable) begin
            state_d        = IDLE;
            wr_ptr_d       = '0;
            string_ready_d = 1'b0;
            sfc_d          = '0;
            match_valid_d  = 1'b0;
            match_lanes_d  = '0;
            text_we        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            wr_ptr_q       <= '0;
            text_len_q     <= '0;
            for (int i = 0; i < num; i++) off_q[i] <= '0;
            seen_we_q      <= 1'b0;
            string_ready_q <= 1'b0;
            sfc_q          <= '0;
            match_valid_q  <= 1'b0;
            match_lanes_q  <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            text_len_q     <= text_len_d;
            off_q          <= off_d;
            seen_we_q      <= seen_we_d;
            string_ready_q <= string_ready_d;
            sfc_q          <= sfc_d;
            match_valid_q  <= match_valid_d;
            match_lanes_q  <= match_lanes_d;
        end
    end

    always_ff @(posedge clk) begin
        if (text_we) text_mem[wr_ptr_q[AW-1:0]] <= text_in;
    end

`ifdef MATCH_COUNT_EN
    logic [15:0] count_q;
    logic [16:0] count_sum;

    assign count_sum = {1'b0, count_q} + 17'($countones(match_lanes_d));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count_q <= '0;
        else if (match_valid_d)
            count_q <= count_sum[16] ? 16'hFFFF : count_sum[15:0];
    end

    assign match_count = count_q;
`else
    assign match_count = 16'h0000;
`endif

    assign string_ready           = string_ready_q;
    assign signal_from_controller = sfc_q;
    assign match_valid            = match_valid_q;
    assign match_lanes            = match_lanes_q;
    assign busy                   = (state_q != IDLE);
    assign dbg_state              = state_q;
    assign dbg_text_len           = text_len_q;

endmodule

// File: tb/tb_weight_match_ctrl.sv
// Directed bench for weight_match_ctrl: text loading, lane compares, finish handling, reset abort.
module tb_weight_match_ctrl;

    logic         clk;
    logic         reset;
    logic         enable;
    logic [7:0]   text_in;
    logic         text_valid;
    logic         text_last;
    logic [127:0] weight_cut;
    logic         weight_enable;
    logic         string_finish;
    logic         string_ready;
    logic [4:0]   signal_from_controller;
    logic         match_valid;
    logic [3:0]   match_lanes;
    logic [15:0]  match_count;
    logic         busy;
    logic [2:0]   dbg_state;
    logic [6:0]   dbg_text_len;

    int n_total = 0;
    int n_bad   = 0;
    int exp_cnt = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  tbuf [0:127];

    weight_match_ctrl dut (
        .clk                    (clk),
        .reset                  (reset),
        .enable                 (enable),
        .text_in                (text_in),
        .text_valid             (text_valid),
        .text_last              (text_last),
        .weight_cut             (weight_cut),
        .weight_enable          (weight_enable),
        .string_finish          (string_finish),
        .string_ready           (string_ready),
        .signal_from_controller (signal_from_controller),
        .match_valid            (match_valid),
        .match_lanes            (match_lanes),
        .match_count            (match_count),
        .busy                   (busy),
        .dbg_state              (dbg_state),
        .dbg_text_len           (dbg_text_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] cnt_exp(input int v);
`ifdef MATCH_COUNT_EN
        return 16'(v);
`else
        return 16'(v * 0);
`endif
    endfunction

    function automatic logic [31:0] lane_bytes(input string s);
        logic [31:0] b;
        b = '0;
        for (int j = 0; j < 4; j++)
            if (j < s.len()) b[j*8 +: 8] = s[j];
        return b;
    endfunction

    function automatic logic [127:0] mk(input string l0, input string l1, input string l2, input string l3);
        return {lane_bytes(l3), lane_bytes(l2), lane_bytes(l1), lane_bytes(l0)};
    endfunction

    task automatic set_text(input string s);
        for (int k = 0; k < s.len(); k++) tbuf[k] = s[k];
    endtask

    // Drives tbuf[0..n-1]; returns at the negedge where the pass has started.
    task automatic load_text(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            text_in    = tbuf[k];
            text_valid = 1'b1;
            text_last  = (k == n - 1);
            @(negedge clk);
            if (k < n - 1) check({tag, "_sr_low"}, 32'(string_ready), 32'd0);
        end
        text_valid = 1'b0;
        text_last  = 1'b0;
        check({tag, "_sr_pulse"}, 32'(string_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic send_chunk(input logic [127:0] w, input logic [4:0] exp_sfc,
                              input logic [3:0] exp_lanes, input string tag);
        exp_q.push_back(32'(exp_sfc));
        weight_cut    = w;
        weight_enable = 1'b1;
        @(negedge clk);
        weight_enable = 1'b0;
        check({tag, "_sfc"}, 32'(signal_from_controller), exp_q.pop_front());
        check({tag, "_mv"}, 32'(match_valid), 32'(exp_lanes != 4'd0));
        check({tag, "_lanes"}, 32'(match_lanes), 32'(exp_lanes));
        check({tag, "_cnt"}, 32'(match_count), 32'(cnt_exp(exp_cnt)));
        @(negedge clk);
        check({tag, "_sfc_run"}, 32'(signal_from_controller), 32'd0);
    endtask

    task automatic finish_pass(input string tag);
        string_finish = 1'b1;
        @(negedge clk);
        check({tag, "_done"}, 32'(dbg_state), 32'd4);
        check({tag, "_done_busy"}, 32'(busy), 32'd1);
        string_finish = 1'b0;
        @(negedge clk);
        check({tag, "_idle"}, 32'(dbg_state), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [127:0] w;
        logic         strobe_seen;
        int           sr_seen;

        reset = 1'b0; enable = 1'b1; text_in = '0; text_valid = 1'b0; text_last = 1'b0;
        weight_cut = '0; weight_enable = 1'b0; string_finish = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sfc", 32'(signal_from_controller), 32'd0);
        check("rst_sr", 32'(string_ready), 32'd0);
        check("rst_mv", 32'(match_valid), 32'd0);
        check("rst_cnt", 32'(match_count), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Lane 0 matches across two chunks, lane 1 breaks and restarts at offset 0.
        set_text("ABCDEFGH");
        load_text(8, "t1");
        check("t1_len", 32'(dbg_text_len), 32'd8);
        @(negedge clk);
        check("t1_sr_once", 32'(string_ready), 32'd0);
        send_chunk(mk("ABCD", "ABXD", "ZZZZ", "ZZZZ"), 5'b10001, 4'b0000, "t1c1");
        exp_cnt = 1;
        send_chunk(mk("EF", "ABCD", "ZZZZ", "ZZZZ"), 5'b10010, 4'b0001, "t1c2");
        send_chunk(mk("ZZ", "EFXX", "ZZZZ", "ZZZZ"), 5'b10000, 4'b0000, "t1c3");
        send_chunk(mk("ZZZZ", "ABCD", "ZZZZ", "ZZZZ"), 5'b10010, 4'b0000, "t1c4");
        finish_pass("t1");

        // Four lanes completing together, then end-of-text and all-padding lanes.
        set_text("AB");
        load_text(2, "t3");
        check("t3_len", 32'(dbg_text_len), 32'd2);
        exp_cnt = 5;
        send_chunk(mk("AB", "AB", "AB", "AB"), 5'b10000, 4'b1111, "t3c1");
        exp_cnt = 7;
        send_chunk(mk("ABC", "A", "", "Z"), 5'b10000, 4'b0110, "t3c2");
        finish_pass("t3");

        // string_finish held before the first chunk is ignored; a chunk with the finish is dropped.
        set_text("ABCDEFGH");
        load_text(8, "t4");
        string_finish = 1'b1;
        repeat (3) @(negedge clk);
        check("t4_no_early_done", 32'(dbg_state), 32'd2);
        send_chunk(mk("ZZZZ", "ZZZZ", "ZZZZ", "ZZZZ"), 5'b10000, 4'b0000, "t4c1");
        string_finish = 1'b0;
        send_chunk(mk("ZZZZ", "ZZZZ", "ZZZZ", "ZZZZ"), 5'b10000, 4'b0000, "t4c2");
        send_chunk(mk("ZZZZ", "ZZZZ", "ZZZZ", "ZZZZ"), 5'b10000, 4'b0000, "t4c3");
        weight_cut    = mk("AB", "", "", "");
        weight_enable = 1'b1;
        string_finish = 1'b1;
        @(negedge clk);
        check("t4_done", 32'(dbg_state), 32'd4);
        check("t4_done_sfc", 32'(signal_from_controller), 32'd0);
        check("t4_done_mv", 32'(match_valid), 32'd0);
        weight_enable = 1'b0;
        string_finish = 1'b0;
        @(negedge clk);
        check("t4_idle", 32'(dbg_state), 32'd0);
        check("t4_idle_busy", 32'(busy), 32'd0);
        check("t4_cnt", 32'(match_count), 32'(cnt_exp(7)));

        // enable low forces IDLE from RUN.
        set_text("AB");
        load_text(2, "te");
        enable = 1'b0;
        @(negedge clk);
        check("te_state", 32'(dbg_state), 32'd0);
        check("te_busy", 32'(busy), 32'd0);
        check("te_sr", 32'(string_ready), 32'd0);
        enable = 1'b1;
        @(negedge clk);

        // 70 bytes into a 64-byte buffer; walk lane 0 through every offset.
        for (int k = 0; k < 70; k++) tbuf[k] = 8'h41 + 8'(k % 26);
        sr_seen = 0;
        load_text(70, "t5");
        check("t5_len", 32'(dbg_text_len), 32'd64);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (string_ready) sr_seen++;
        end
        check("t5_sr_single", 32'(sr_seen), 32'd0);
        for (int o = 0; o < 16; o++) begin
            w = mk("", "ZZZZ", "ZZZZ", "ZZZZ");
            w[31:0] = {tbuf[4*o+3], tbuf[4*o+2], tbuf[4*o+1], tbuf[4*o]};
            send_chunk(w, (o < 15) ? 5'b10001 : 5'b10000, 4'b0000, $sformatf("t5o%0d", o));
        end
        finish_pass("t5");

        // Reset during CMP aborts the pass.
        set_text("ABCD");
        load_text(4, "t6");
        weight_cut    = mk("ABCD", "ZZZZ", "ZZZZ", "ZZZZ");
        weight_enable = 1'b1;
        @(negedge clk);
        weight_enable = 1'b0;
        check("t6_cmp_sfc", 32'(signal_from_controller), 32'b10001);
        reset = 1'b0;
        #1;
        check("t6_rst_sfc", 32'(signal_from_controller), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_state", 32'(dbg_state), 32'd0);
        check("t6_rst_cnt", 32'(match_count), 32'd0);
        check("t6_rst_len", 32'(dbg_text_len), 32'd0);
        strobe_seen = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        weight_enable = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            strobe_seen = strobe_seen | signal_from_controller[4];
        end
        weight_enable = 1'b0;
        check("t6_no_strobe", 32'(strobe_seen), 32'd0);
        check("t6_idle", 32'(dbg_state), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/weight_match_ctrl.md
WEIGHT_MATCH_CTRL -- requirements
Module: weight_match_ctrl

Interface
REQ-001 SHALL provide parameter DWIDTH, default 8, byte width of text and weight symbols.
REQ-002 SHALL provide parameter num, default 4, number of lanes and number of bytes per lane chunk.
REQ-003 SHALL provide parameter TEXT_LEN, default 64, text buffer depth in bytes; a multiple of num.
REQ-004 SHALL have the port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have the port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have the port enable  input  1  when low, synchronously forces IDLE and clears all outputs except match_count.
REQ-007 SHALL have the ports text_in  input  DWIDTH, text_valid  input  1, and text_last  input  1, forming the text byte stream.
REQ-008 SHALL have the port weight_cut  input  num*num*DWIDTH  per-lane chunks; lane i occupies bytes i*num..i*num+num-1.
REQ-009 SHALL have the ports weight_enable  input  1 (chunk valid) and string_finish  input  1 (producer pass complete).
REQ-010 SHALL have the port string_ready  output  1  one-cycle pulse starting a producer pass.
REQ-011 SHALL have the port signal_from_controller  output  num+1  where bit i=1 continues lane i's weight, bit i=0 requests the next weight, and bit num is the advance strobe.
REQ-012 SHALL have the ports match_valid  output  1, match_lanes  output  num, match_count  output  16, and busy  output  1.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, RUN, CMP and DONE.
REQ-014 SHALL move IDLE->LOAD on the first text_valid; in LOAD, SHALL write text_in to text[wr_ptr], increment wr_ptr, and latch text_len=wr_ptr+1 on text_last.
REQ-015 SHALL drop bytes beyond TEXT_LEN while still honouring text_last.
REQ-016 SHALL, in the cycle after text_last, pulse string_ready for one cycle, clear all lane offsets and continue flags, and enter RUN.
REQ-017 SHALL, in RUN, register the compare result into CMP on weight_enable=1; in CMP, SHALL drive bit num=1 plus the cont bits for exactly one cycle, then return to RUN.
REQ-018 SHALL ensure signal_from_controller is 0 in every state other than CMP.
REQ-019 SHALL compare lane i's byte j against text[off_i*num+j]; a 0x00 weight byte and all bytes after it are padding and always match; positions >= text_len always mismatch.
REQ-020 SHALL mark a lane final when its chunk contains any 0x00 byte; weight images guarantee a 0x00 terminator in every final chunk.
REQ-021 SHALL set cont_i=matched_i & ~final_i & (off_i+1 < TEXT_LEN/num); when cont_i=1, off_i SHALL increment, otherwise off_i SHALL become 0.
REQ-022 SHALL, when matched_i & final_i, set match_lanes[i] and pulse match_valid in CMP; with several lanes completing together, the corresponding bits SHALL all be set in the same cycle.
REQ-023 SHALL ignore string_finish until the first weight_enable of a pass; after that, string_finish=1 in RUN SHALL go to DONE, and a chunk arriving in the same cycle SHALL be discarded.
REQ-024 SHALL hold DONE for one cycle, then go to IDLE; busy SHALL be high in every state except IDLE.

Reset
REQ-025 SHALL, on reset low, asynchronously set state=IDLE and clear wr_ptr, text_len, offsets, cont flags, string_ready, signal_from_controller, match_valid, match_lanes, match_count and busy; text contents SHALL remain undefined.
REQ-026 SHALL, on reset asserted mid-pass, abort the pass with no further advance strobe after release.

Configuration
REQ-027 SHALL, with MATCH_COUNT_EN defined, increment match_count by popcount(match_lanes) on each match_valid, saturating at 16'hFFFF, cleared only by reset.
REQ-028 SHALL, without MATCH_COUNT_EN, tie match_count to 0 and omit the counter logic.

Verification
REQ-029 SHALL cover: text "ABCDEFGH" loaded, lane0 chunks "ABCD" then "EF\0\0" -> first CMP bit0=1, second match_lanes=4'b0001, match_valid=1, match_count=1.
REQ-030 SHALL cover: lane1 chunk "ABXD" -> signal_from_controller[1]=0, off_1 returns to 0, no match.
REQ-031 SHALL cover: all four lanes "AB\0\0" against text "AB" -> match_lanes=4'b1111, match_count=4 (MATCH_COUNT_EN).
REQ-032 SHALL cover: string_finish=1 held before the first weight_enable, then asserted after three chunks -> no early DONE; DONE for one cycle, then IDLE, busy=0.
REQ-033 SHALL cover: 70 text bytes sent with TEXT_LEN=64 -> text_len=64, string_ready pulses once after text_last.
REQ-034 SHALL cover: reset low during CMP -> all outputs 0 immediately; no bit num strobe after release.
